// File: rtl/mgt_tx_startup_ctrl.sv
// mgt_tx_startup_ctrl: transmit-MGT startup/reset sequencer for the trigger optical link (40 MHz)
//   Sequences PLL reset, per-lane GT reset, optional GTXTEST divider-reset double pulse and a
//   realign pulse, then waits for mgt_startup_done and qualifies ready_o. IPbus manual control
//   bits are merged into the registered outputs and can force re-entry into any sequence phase.
//   Ports: clock_40, reset_i (async, active-high); mgt_startup_done, force_not_ready;
//   ext_* manual controls in; pll_reset_o, mgt_reset_o[3:0], gtxtest_reset_o, mgt_realign_o,
//   txreset_o, txpowerdown_o, txpowerdown_mode_o[1:0], txpllpowerdown_o, gtxtest_start_o, ready_o out.
//   Define MGT_CTRL_TMR_EN to triplicate the state register and counter with majority voting.
module mgt_tx_startup_ctrl #(
  parameter int          FPGA_TYPE_IS_VIRTEX6 = 0,
  parameter int          FPGA_TYPE_IS_ARTIX7  = 0,
  parameter int          ALLOW_RETRY          = 0,
  parameter int unsigned PLL_RESET_CYCLES     = 64,
  parameter int unsigned MGT_RESET_CYCLES     = 64,
  parameter int unsigned GTXTEST_CYCLES       = 16,
  parameter int unsigned TIMEOUT_CYCLES       = 4096
) (
  input  logic       clock_40,
  input  logic       reset_i,
  input  logic       mgt_startup_done,
  input  logic       force_not_ready,
  input  logic       ext_pll_reset_i,
  input  logic [3:0] ext_mgt_reset_i,
  input  logic       ext_gtxtest_start_i,
  input  logic       ext_txreset_i,
  input  logic       ext_mgt_realign_i,
  input  logic       ext_txpowerdown_i,
  input  logic [1:0] ext_txpowerdown_mode_i,
  input  logic       ext_txpllpowerdown_i,
  output logic       pll_reset_o,
  output logic [3:0] mgt_reset_o,
  output logic       gtxtest_start_o,
  output logic       txreset_o,
  output logic       mgt_realign_o,
  output logic       txpowerdown_o,
  output logic [1:0] txpowerdown_mode_o,
  output logic       txpllpowerdown_o,
  output logic       gtxtest_reset_o,
  output logic       ready_o
);
  // Virtex-6 wins when both part flags are set; Artix-7 and other parts skip GTXTEST
  localparam bit GTX_SEQ = (FPGA_TYPE_IS_VIRTEX6 != 0) ? 1'b1 : (FPGA_TYPE_IS_ARTIX7 != 0) ? 1'b0 : 1'b0;
  typedef enum logic [3:0] {
    PLL_RST, MGT_RST, GT_A, GAP_A, GT_B, GAP_B, REALIGN, WAIT_DONE, READY
  } state_t;
  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt, lim;
  logic        restart, done;
  assign lim = state == PLL_RST ? PLL_RESET_CYCLES - 1 : state == MGT_RST ? MGT_RESET_CYCLES - 1 : GTXTEST_CYCLES - 1;
  assign done = cnt == lim;
  assign restart = ext_pll_reset_i | (|ext_mgt_reset_i) | (ext_gtxtest_start_i & GTX_SEQ);
  always_comb begin
    state_nxt = state;
    case (state)
      PLL_RST:   state_nxt = done ? MGT_RST : PLL_RST;
      MGT_RST:   state_nxt = done ? (GTX_SEQ ? GT_A : REALIGN) : MGT_RST;
      GT_A:      state_nxt = done ? GAP_A : GT_A;
      GAP_A:     state_nxt = done ? GT_B : GAP_A;
      GT_B:      state_nxt = done ? GAP_B : GT_B;
      GAP_B:     state_nxt = done ? REALIGN : GAP_B;
      REALIGN:   state_nxt = WAIT_DONE;
      WAIT_DONE: state_nxt = mgt_startup_done ? READY
                           : (ALLOW_RETRY != 0 && cnt == TIMEOUT_CYCLES - 1) ? PLL_RST : WAIT_DONE;
      READY:     state_nxt = mgt_startup_done ? READY : WAIT_DONE;
      default:   state_nxt = PLL_RST;
    endcase
    // manual restarts override the sequence; a held level keeps re-entering with a cleared counter
    state_nxt = ext_pll_reset_i ? PLL_RST : (|ext_mgt_reset_i) ? MGT_RST
              : (ext_gtxtest_start_i && GTX_SEQ) ? GT_A : state_nxt;
    cnt_nxt = (restart || state_nxt != state) ? 32'd0 : cnt + 32'd1;
  end
`ifdef MGT_CTRL_TMR_EN
  logic [3:0]  st_q  [3];
  logic [31:0] cnt_q [3];
  assign state = state_t'((st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]));
  assign cnt = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
  always_ff @(posedge clock_40 or posedge reset_i)
    if (reset_i)
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= PLL_RST;
        cnt_q[i] <= '0;
      end
    else
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= state_nxt;
        cnt_q[i] <= cnt_nxt;
      end
`else
  always_ff @(posedge clock_40 or posedge reset_i)
    if (reset_i) begin
      state <= PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
`endif
  // sequence terms are taken from the next state so each pulse lines up with its state's cycles;
  // ready_o is qualified by the current state, giving two cycles from done to ready
  always_ff @(posedge clock_40 or posedge reset_i)
    if (reset_i) begin
      pll_reset_o        <= 1'b1;
      mgt_reset_o        <= 4'hF;
      gtxtest_reset_o    <= 1'b0;
      mgt_realign_o      <= 1'b0;
      txreset_o          <= 1'b0;
      txpowerdown_o      <= 1'b0;
      txpowerdown_mode_o <= 2'b00;
      txpllpowerdown_o   <= 1'b0;
      gtxtest_start_o    <= 1'b0;
      ready_o            <= 1'b0;
    end else begin
      pll_reset_o        <= (state_nxt == PLL_RST) | ext_pll_reset_i;
      mgt_reset_o        <= {4{state_nxt == PLL_RST || state_nxt == MGT_RST}} | ext_mgt_reset_i;
      gtxtest_reset_o    <= state_nxt == GT_A || state_nxt == GT_B;
      mgt_realign_o      <= (state_nxt == REALIGN) | ext_mgt_realign_i;
      txreset_o          <= ext_txreset_i;
      txpowerdown_o      <= ext_txpowerdown_i;
      txpowerdown_mode_o <= ext_txpowerdown_mode_i;
      txpllpowerdown_o   <= ext_txpllpowerdown_i;
      gtxtest_start_o    <= ext_gtxtest_start_i;
      ready_o            <= (state == READY) & mgt_startup_done & ~force_not_ready;
    end
endmodule

// File: tb/tb_mgt_tx_startup_ctrl.sv
// tb_mgt_tx_startup_ctrl: scoreboard bench for a Virtex-6 (no retry) and an Artix-7 (retry) instance
module tb_mgt_tx_startup_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0, fnr = 1'b0, ext_pll = 1'b0, ext_gts = 1'b0, ext_txreset = 1'b0;
  logic       ext_realign = 1'b0, ext_txpd = 1'b0, ext_pllpd = 1'b0;
  logic [3:0] ext_mgt = 4'h0;
  logic [1:0] ext_mode = 2'b00;
  logic       a_pll, a_gts, a_txreset, a_realign, a_txpd, a_pllpd, a_gtx, a_ready;
  logic       b_pll, b_gts, b_txreset, b_realign, b_txpd, b_pllpd, b_gtx, b_ready;
  logic [3:0] a_mgt, b_mgt;
  logic [1:0] a_mode, b_mode;
  logic [13:0] got_a, got_b;
  logic [13:0] sb[$];
  int checks = 0, errors = 0, cyc = 0;
  int n[2], w[2];
  bit rd[2];
  bit g[2] = '{1'b1, 1'b0};
  bit retry[2] = '{1'b0, 1'b1};
  localparam logic [13:0] RST_V = {1'b1, 4'hF, 9'b0};
  always #5 clk = ~clk;
  mgt_tx_startup_ctrl #(.FPGA_TYPE_IS_VIRTEX6(1)) dut_a (
    .clock_40(clk), .reset_i(rst), .mgt_startup_done(done), .force_not_ready(fnr),
    .ext_pll_reset_i(ext_pll), .ext_mgt_reset_i(ext_mgt), .ext_gtxtest_start_i(ext_gts),
    .ext_txreset_i(ext_txreset), .ext_mgt_realign_i(ext_realign), .ext_txpowerdown_i(ext_txpd),
    .ext_txpowerdown_mode_i(ext_mode), .ext_txpllpowerdown_i(ext_pllpd),
    .pll_reset_o(a_pll), .mgt_reset_o(a_mgt), .gtxtest_start_o(a_gts), .txreset_o(a_txreset),
    .mgt_realign_o(a_realign), .txpowerdown_o(a_txpd), .txpowerdown_mode_o(a_mode),
    .txpllpowerdown_o(a_pllpd), .gtxtest_reset_o(a_gtx), .ready_o(a_ready));
  mgt_tx_startup_ctrl #(.FPGA_TYPE_IS_ARTIX7(1), .ALLOW_RETRY(1)) dut_b (
    .clock_40(clk), .reset_i(rst), .mgt_startup_done(done), .force_not_ready(fnr),
    .ext_pll_reset_i(ext_pll), .ext_mgt_reset_i(ext_mgt), .ext_gtxtest_start_i(ext_gts),
    .ext_txreset_i(ext_txreset), .ext_mgt_realign_i(ext_realign), .ext_txpowerdown_i(ext_txpd),
    .ext_txpowerdown_mode_i(ext_mode), .ext_txpllpowerdown_i(ext_pllpd),
    .pll_reset_o(b_pll), .mgt_reset_o(b_mgt), .gtxtest_start_o(b_gts), .txreset_o(b_txreset),
    .mgt_realign_o(b_realign), .txpowerdown_o(b_txpd), .txpowerdown_mode_o(b_mode),
    .txpllpowerdown_o(b_pllpd), .gtxtest_reset_o(b_gtx), .ready_o(b_ready));
  assign got_a = {a_pll, a_mgt, a_gtx, a_realign, a_ready, a_txreset, a_txpd, a_mode, a_pllpd, a_gts};
  assign got_b = {b_pll, b_mgt, b_gtx, b_realign, b_ready, b_txreset, b_txpd, b_mode, b_pllpd, b_gts};
  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0;
      w[i] = 0;
      rd[i] = 1'b0;
    end
  endtask
  // timeline model: n = cycles elapsed in the startup sequence, w = cycles spent waiting for done
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      int sl;
      logic r;
      sl = g[i] ? 193 : 129;
      r = rd[i] && done && !fnr;
      if (ext_pll) begin n[i] = 0; rd[i] = 1'b0; end
      else if (|ext_mgt) begin n[i] = 64; rd[i] = 1'b0; end
      else if (ext_gts && g[i]) begin n[i] = 128; rd[i] = 1'b0; end
      else if (n[i] < sl) begin n[i]++; w[i] = 0; end
      else if (rd[i]) begin if (!done) begin rd[i] = 1'b0; w[i] = 0; end end
      else if (done) rd[i] = 1'b1;
      else if (retry[i] && w[i] == 4095) n[i] = 0;
      else w[i]++;
      sb.push_back({n[i] < 64 || ext_pll, {4{n[i] < 128}} | ext_mgt,
                    g[i] && ((n[i] >= 128 && n[i] < 144) || (n[i] >= 160 && n[i] < 176)),
                    n[i] == sl - 1 || ext_realign, r, ext_txreset, ext_txpd, ext_mode, ext_pllpd, ext_gts});
    end
    @(posedge clk);
    #1;
    check($sformatf("v6 cycle %0d", cyc), got_a, sb.pop_front());
    check($sformatf("a7 cycle %0d", cyc), got_b, sb.pop_front());
    cyc++;
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("v6 in reset", got_a, RST_V);
    check("a7 in reset", got_b, RST_V);
    rst = 1'b0;
    model_reset();
    #1;
    check("v6 after release", got_a, RST_V);
    check("a7 after release", got_b, RST_V);
    run(300);
    done = 1'b1;
    run(6);
    fnr = 1'b1;
    run(3);
    fnr = 1'b0;
    run(3);
    done = 1'b0;
    run(3);
    done = 1'b1;
    run(4);
    ext_mgt = 4'b0100;
    step();
    ext_mgt = 4'h0;
    run(200);
    for (int i = 0; i < 40; i++) begin
      done = 1'($urandom_range(0, 3) != 0);
      fnr = 1'($urandom_range(0, 3) == 0);
      ext_gts = 1'($urandom_range(0, 7) == 0);
      ext_txreset = 1'($urandom);
      ext_realign = 1'($urandom);
      ext_txpd = 1'($urandom);
      ext_mode = 2'($urandom);
      ext_pllpd = 1'($urandom);
      step();
    end
    {fnr, ext_gts, ext_txreset, ext_realign, ext_txpd, ext_mode, ext_pllpd} = '0;
    done = 1'b0;
    run(4400);
    ext_pll = 1'b1;
    step();
    ext_pll = 1'b0;
    run(165);
    #3;
    rst = 1'b1;
    #1;
    check("v6 async reset in GT_B", got_a, RST_V);
    check("a7 async reset", got_b, RST_V);
    @(posedge clk);
    #1;
    check("v6 held reset", got_a, RST_V);
    rst = 1'b0;
    model_reset();
    run(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
